cbd_polyvec_streamer: RTL and testbench

Consumer-side counterpart of the 2k-polynomial CBD sampler. It captures a completed vector of 2·K signed 8-bit CBD polynomials in one cycle, converts each coefficient to its canonical mod-q representative in [0, q-1], and drains the result as a valid/ready stream of LANES coefficients per beat. The stream feeds the NTT/polynomial memory loaders, which must not have to hold the sampler's wide parallel output bus.

---
 rtl/cbd_polyvec_streamer.sv | 124 ++++++++++++
 tb/tb_cbd_polyvec_streamer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cbd_polyvec_streamer.sv
// Captures a full vector of 2K signed 8-bit CBD polynomials and drains it as a
// valid/ready stream of LANES canonical mod-Q coefficients per beat.
module cbd_polyvec_streamer #(
    parameter int K     = 3,
    parameter int N     = 256,
    parameter int LANES = 4,
    parameter int Q     = 3329
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic [2*K*N*8-1:0]           polyvec_i,
    output logic                         busy_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [LANES*12-1:0]          data_o,
    output logic [$clog2(2*K)-1:0]       poly_idx_o,
    output logic                         last_o,
    output logic                         vec_last_o,
    output logic                         done_o
);

    localparam int DATA_W = 8;
    localparam int OUT_W  = 12;
    localparam int NPOLY  = 2 * K;
    localparam int BEATS  = N / LANES;
    localparam int PW     = $clog2(NPOLY);
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                      state, state_nxt;
    logic [BW-1:0]               beat_cnt;
    logic [PW-1:0]               poly_cnt;
    logic                        done_p0;
    logic [NPOLY*N*DATA_W-1:0]   cap_p0;
    logic                        load_acc;
    logic                        hs;
    logic                        beat_end;
    logic                        vec_end;

    // Negative coefficients fold up by Q; the 13-bit signed sum is always
    // within [0, Q-1] for the full 8-bit input range, so the low 12 bits suffice.
    function automatic logic [OUT_W-1:0] to_modq(input logic signed [DATA_W-1:0] c);
        logic signed [12:0] ext;
        logic signed [12:0] sum;
        ext = 13'(c);
        if (ext < 0) sum = ext + 13'(Q);
        else         sum = ext;
        return sum[OUT_W-1:0];
    endfunction

    assign beat_end = (beat_cnt == BW'(BEATS - 1));
    assign vec_end  = beat_end && (poly_cnt == PW'(NPOLY - 1));

    always_comb begin
        state_nxt = state;
        load_acc  = 1'b0;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                // The done cycle still counts as busy, so a reload waits one more cycle.
                if (load_i && !done_p0) begin
                    load_acc  = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (ready_i) begin
                    hs = 1'b1;
                    if (vec_end) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            beat_cnt <= '0;
            poly_cnt <= '0;
            done_p0  <= 1'b0;
        end else begin
            state   <= state_nxt;
            done_p0 <= hs && vec_end;
            if (load_acc) begin
                beat_cnt <= '0;
                poly_cnt <= '0;
            end else if (hs) begin
                if (beat_end) begin
                    beat_cnt <= '0;
                    poly_cnt <= vec_end ? '0 : poly_cnt + PW'(1);
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end
        end
    end

    // Capture stage: data only, written solely on an accepted load.
    always_ff @(posedge clk_i) begin
        if (load_acc && !rst_i) cap_p0 <= polyvec_i;
    end

    always_comb begin
        data_o = '0;
        for (int l = 0; l < LANES; l++) begin
            data_o[l*OUT_W +: OUT_W] =
                to_modq(cap_p0[(int'(poly_cnt) * N + int'(beat_cnt) * LANES + l) * DATA_W +: DATA_W]);
        end
    end

    assign valid_o    = (state == STREAM);
    assign busy_o     = (state == STREAM) || done_p0;
    assign done_o     = done_p0;
    assign poly_idx_o = poly_cnt;
    assign last_o     = (state == STREAM) && beat_end;
    assign vec_last_o = (state == STREAM) && vec_end;

endmodule

// File: tb/tb_cbd_polyvec_streamer.sv
// Directed bench for cbd_polyvec_streamer: a beat-queue scoreboard checks every
// cycle, and literal values pin the conversion and the drain timing.
module tb_cbd_polyvec_streamer;

    localparam int K     = 3;
    localparam int N     = 256;
    localparam int LANES = 4;
    localparam int Q     = 3329;
    localparam int NC    = 2 * K * N;
    localparam int BEATS = N / LANES;

    logic                    clk = 1'b0;
    logic                    rst_i = 1'b1;
    logic                    load_i = 1'b0;
    logic [NC*8-1:0]         polyvec_i = '0;
    logic                    busy_o, valid_o, last_o, vec_last_o, done_o;
    logic                    ready_i = 1'b0;
    logic [LANES*12-1:0]     data_o;
    logic [$clog2(2*K)-1:0]  poly_idx_o;

    cbd_polyvec_streamer #(.K(K), .N(N), .LANES(LANES), .Q(Q)) dut (
        .clk_i(clk), .rst_i(rst_i), .load_i(load_i), .polyvec_i(polyvec_i),
        .busy_o(busy_o), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .poly_idx_o(poly_idx_o), .last_o(last_o), .vec_last_o(vec_last_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int coefv [NC];
    bit mon_en = 1'b0;

    typedef struct {
        logic [LANES*12-1:0] data;
        int                  poly;
        bit                  last;
        bit                  vlast;
    } beat_t;

    beat_t exp_q[$];
    bit    m_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int pat(input int kind, input int i);
        case (kind)
            0:       return (i % 7) - 3;
            1: begin
                case (i % 4)
                    0:       return -128;
                    1:       return -1;
                    2:       return 0;
                    default: return 127;
                endcase
            end
            2:       return (i % 11) - 5;
            default: return (i % 13) - 6;
        endcase
    endfunction

    task automatic set_pattern(input int kind);
        for (int i = 0; i < NC; i++) begin
            coefv[i] = pat(kind, i);
            polyvec_i[i*8 +: 8] = 8'(coefv[i]);
        end
    endtask

    // Expected beats of a whole vector, straight from the mod-Q rule.
    task automatic push_vector();
        beat_t b;
        int    e;
        for (int p = 0; p < 2 * K; p++) begin
            for (int bt = 0; bt < BEATS; bt++) begin
                b.data = '0;
                for (int l = 0; l < LANES; l++) begin
                    e = coefv[p * N + bt * LANES + l];
                    if (e < 0) e = e + Q;
                    b.data[l*12 +: 12] = 12'(e);
                end
                b.poly  = p;
                b.last  = (bt == BEATS - 1);
                b.vlast = (bt == BEATS - 1) && (p == 2 * K - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    always @(negedge clk) begin
        bit idle;
        if (mon_en) begin
            chk("valid_o", 64'(valid_o), 64'(exp_q.size() > 0));
            chk("busy_o", 64'(busy_o), 64'((exp_q.size() > 0) || m_done));
            chk("done_o", 64'(done_o), 64'(m_done));
            if (exp_q.size() > 0) begin
                chk("data_o", 64'(data_o), 64'(exp_q[0].data));
                chk("poly_idx_o", 64'(poly_idx_o), 64'(exp_q[0].poly));
                chk("last_o", 64'(last_o), 64'(exp_q[0].last));
                chk("vec_last_o", 64'(vec_last_o), 64'(exp_q[0].vlast));
            end
            if (rst_i) begin
                exp_q.delete();
                m_done = 1'b0;
            end else begin
                idle   = (exp_q.size() == 0) && !m_done;
                m_done = 1'b0;
                if (exp_q.size() > 0 && ready_i) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) m_done = 1'b1;
                end else if (idle && load_i) begin
                    push_vector();
                end
            end
        end
    end

    task automatic start(input int kind);
        @(posedge clk); #1;
        set_pattern(kind);
        load_i = 1'b1;
    endtask

    // Runs from the load edge until done_o; ncyc counts cycles after the load edge.
    task automatic run_until_done(input bit rnd, input int max_cyc, output int ncyc,
                                  output int nvalid, output int nlast, output int nvlast,
                                  output logic [LANES*12-1:0] d0, output logic [LANES*12-1:0] d1);
        ncyc = 0; nvalid = 0; nlast = 0; nvlast = 0; d0 = '0; d1 = '0;
        forever begin
            @(posedge clk); #1;
            load_i = 1'b0;
            ncyc++;
            if (ncyc == 1) d0 = data_o;
            if (ncyc == 2) d1 = data_o;
            if (done_o) break;
            if (valid_o && ready_i) begin
                nvalid++;
                if (last_o) nlast++;
                if (vec_last_o) nvlast++;
            end
            if (ncyc >= max_cyc) begin
                chk("done_timeout", 64'(ncyc), 64'(0));
                break;
            end
            if (rnd) ready_i = ($urandom_range(0, 99) < 30);
        end
    endtask

    int ncyc, nvalid, nlast, nvlast, ndone;
    logic [LANES*12-1:0] d0, d1;

    initial begin
        // Reset, with a coincident load that must lose.
        set_pattern(0);
        load_i = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        load_i = 1'b0;
        rst_i  = 1'b0;
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_poly", 64'(poly_idx_o), 64'(0));
        chk("rst_last", 64'(last_o | vec_last_o | done_o), 64'(0));
        for (int i = 0; i < 10; i++) begin
            ready_i = i[0];
            @(posedge clk); #1;
            chk("idle_valid", 64'(valid_o), 64'(0));
        end

        // Full-throughput drain.
        ready_i = 1'b1;
        start(0);
        run_until_done(1'b0, 1000, ncyc, nvalid, nlast, nvlast, d0, d1);
        chk("full_done_cycle", 64'(ncyc), 64'(385));
        chk("full_beats", 64'(nvalid), 64'(384));
        chk("full_last_cnt", 64'(nlast), 64'(6));
        chk("full_vlast_cnt", 64'(nvlast), 64'(1));
        chk("full_beat0", 64'(d0), 64'({12'd0, 12'd3328, 12'd3327, 12'd3326}));
        chk("full_beat1", 64'(d1), 64'({12'd3326, 12'd3, 12'd2, 12'd1}));

        // Random backpressure, same vector.
        start(0);
        run_until_done(1'b1, 5000, ncyc, nvalid, nlast, nvlast, d0, d1);
        chk("bp_beats", 64'(nvalid), 64'(384));
        chk("bp_vlast_cnt", 64'(nvlast), 64'(1));

        // Extreme values.
        ready_i = 1'b1;
        start(1);
        run_until_done(1'b0, 1000, ncyc, nvalid, nlast, nvlast, d0, d1);
        chk("ext_beat0", 64'(d0), 64'({12'd127, 12'd0, 12'd3328, 12'd3201}));

        // Loads while busy are ignored; the one after done_o is taken.
        start(2);
        repeat (11) begin
            @(posedge clk); #1;
            load_i = 1'b0;
        end
        set_pattern(3);
        load_i = 1'b1;
        @(posedge clk); #1;
        load_i = 1'b0;
        ndone = 0;
        while (!done_o && ndone < 1000) begin
            @(posedge clk); #1;
            ndone++;
        end
        chk("busy_done_seen", 64'(done_o), 64'(1));
        load_i = 1'b1;
        @(posedge clk); #1;
        chk("done_cycle_load_ignored", 64'(valid_o), 64'(0));
        run_until_done(1'b0, 1000, ncyc, nvalid, nlast, nvlast, d0, d1);
        chk("reload_done_cycle", 64'(ncyc), 64'(385));
        chk("reload_beat0", 64'(d0), 64'({12'd3326, 12'd3325, 12'd3324, 12'd3323}));

        // Mid-stream reset, then a fresh load.
        start(0);
        repeat (201) begin
            @(posedge clk); #1;
            load_i = 1'b0;
        end
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("mrst_valid", 64'(valid_o), 64'(0));
        chk("mrst_busy", 64'(busy_o), 64'(0));
        chk("mrst_poly", 64'(poly_idx_o), 64'(0));
        chk("mrst_flags", 64'(last_o | vec_last_o | done_o), 64'(0));
        ndone = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (done_o) ndone++;
        end
        chk("mrst_no_done", 64'(ndone), 64'(0));
        start(1);
        @(posedge clk); #1;
        load_i = 1'b0;
        chk("mrst_new_poly", 64'(poly_idx_o), 64'(0));
        chk("mrst_new_beat0", 64'(data_o), 64'({12'd127, 12'd0, 12'd3328, 12'd3201}));
        ndone = 0;
        while (!done_o && ndone < 1000) begin
            @(posedge clk); #1;
            ndone++;
        end
        chk("mrst_new_done", 64'(ndone), 64'(384));
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
